// File: rtl/fft_sdf_ctrl.sv
// rtl/fft_sdf_ctrl.sv - sequencer for a radix-2 DIF single-path delay-feedback FFT pipeline
// Stage enables, butterfly/twiddle control, drain flush and bit-reversed output tagging.
module fft_sdf_ctrl #(
  parameter int LOG2N     = 8,
  parameter int STAGE_LAT = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic                         in_sop,
  input  logic                         inv_req,
  output logic                         in_ready,
  output logic                         en,
  output logic                         flush,
  output logic                         inv,
  output logic [LOG2N-1:0]             bf_sel,
  output logic [LOG2N*(LOG2N-1)-1:0]   tw_addr,
  output logic                         out_valid,
  output logic                         out_sop,
  output logic                         out_eop,
  output logic [LOG2N-1:0]             out_idx,
  output logic                         busy,
  output logic                         sop_err
);
  localparam int N  = 1 << LOG2N;
  localparam int L  = N - 1 + LOG2N * STAGE_LAT;
  localparam int LW = LOG2N + 3;
  localparam int AW = LOG2N - 1;
  localparam logic [LW-1:0]    L_V  = LW'(L);
  localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t           state, state_nx;
  logic [LOG2N-1:0] ecnt;
  logic [LOG2N-1:0] out_cnt;
  logic [LW-1:0]    lat_cnt;
  logic [3:0]       fin, fout;
  logic             inv_q;
  logic             last_frame;

  assign last_frame = ((fout + 4'd1) == fin);

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    en        = 1'b0;
    flush     = 1'b0;
    sop_err   = 1'b0;
    out_valid = 1'b0;
    out_sop   = 1'b0;
    out_eop   = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          in_ready = 1'b1;
          en       = in_valid & in_sop;
          if (en) state_nx = RUN;
        end
        RUN: begin
          if (ecnt != '0) begin
            in_ready = 1'b1;
            en       = in_valid;
            sop_err  = in_valid & in_sop;
          end else begin
            // Back-to-back frame only if it starts cleanly with the same direction
            in_ready = in_valid & in_sop & (inv_req == inv_q);
            en       = in_ready;
            if (!in_ready) state_nx = FLUSH;
          end
        end
        FLUSH: begin
          en    = 1'b1;
          flush = 1'b1;
        end
        default: state_nx = IDLE;
      endcase
      out_valid = en & (lat_cnt == L_V) & (fout != fin);
      out_sop   = out_valid & (out_cnt == '0);
      out_eop   = out_valid & (out_cnt == LAST);
      if (state == FLUSH && out_eop && last_frame) state_nx = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ecnt    <= '0;
      out_cnt <= '0;
      lat_cnt <= '0;
      fin     <= '0;
      fout    <= '0;
      inv_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE) begin
        if (en) begin
          inv_q   <= inv_req;
          ecnt    <= LOG2N'(1);
          lat_cnt <= LW'(1);
          fin     <= 4'd1;
          fout    <= 4'd0;
          out_cnt <= '0;
        end
      end else if (en) begin
        // Park ecnt at 0 on drain completion so the next burst's first sample sees count 0
        ecnt <= (state_nx == IDLE) ? '0 : ecnt + LOG2N'(1);
        if (lat_cnt != L_V) lat_cnt <= lat_cnt + LW'(1);
        if (state == RUN && ecnt == '0) fin <= fin + 4'd1;
        if (out_valid) out_cnt <= out_cnt + LOG2N'(1);
        if (out_eop) fout <= fout + 4'd1;
      end
    end
  end

  for (genvar s = 0; s < LOG2N; s++) begin : g_stage
    localparam int OFF = N - (1 << (LOG2N - s)) + s * STAGE_LAT;
    localparam logic [LOG2N-1:0] OFF_V = LOG2N'(OFF);
    localparam logic [LOG2N-1:0] MASK  = LOG2N'((1 << (LOG2N - 1 - s)) - 1);
    logic [LOG2N-1:0] sc;
    assign sc = ecnt - OFF_V;
    assign bf_sel[s] = sc[LOG2N-1-s] & ~rst;
    assign tw_addr[s*AW +: AW] = rst ? '0 : AW'((sc & MASK) << s);
  end

  always_comb begin
    out_idx = '0;
    for (int i = 0; i < LOG2N; i++) out_idx[i] = out_cnt[LOG2N-1-i] & ~rst;
  end

  assign inv  = inv_q & ~rst;
  assign busy = (state != IDLE) & ~rst;

endmodule

// File: tb/tb_fft_sdf_ctrl.sv
// tb/tb_fft_sdf_ctrl.sv - randomized self-checking bench for fft_sdf_ctrl
module tb_fft_sdf_ctrl;
  localparam int LOG2N = 3;
  localparam int SLAT  = 1;
  localparam int N     = 1 << LOG2N;
  localparam int L     = N - 1 + LOG2N * SLAT;
  localparam int AW    = LOG2N - 1;

  logic clk = 1'b0;
  logic rst, in_valid, in_sop, inv_req;
  logic in_ready, en, flush, inv, out_valid, out_sop, out_eop, busy, sop_err;
  logic [LOG2N-1:0] bf_sel, out_idx;
  logic [LOG2N*AW-1:0] tw_addr;

  fft_sdf_ctrl #(.LOG2N(LOG2N), .STAGE_LAT(SLAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sop(in_sop), .inv_req(inv_req),
    .in_ready(in_ready), .en(en), .flush(flush), .inv(inv), .bf_sel(bf_sel),
    .tw_addr(tw_addr), .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
    .out_idx(out_idx), .busy(busy), .sop_err(sop_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference: phase 0 idle, 1 run, 2 flush; e = enables since burst start; nin = frames accepted
  int phase = 0;
  int e     = 0;
  int nin   = 0;
  bit minv  = 1'b0;
  bit inv_sel = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic do_cycle(input bit r);
    int pos, k, j, sc, off;
    bit x_rdy, x_en, x_fl, x_err, x_ov, x_sop, x_eop, x_inv, x_busy;
    logic [LOG2N-1:0] x_bf, x_idx;
    logic [LOG2N*AW-1:0] x_tw;
    logic [LOG2N-1:0] jm;

    @(negedge clk);
    cyc++;
    rst = r;
    pos = e % N;
    in_valid = ($urandom % 6) != 0;
    if (phase == 0 || (phase == 1 && pos == 0)) in_sop = ($urandom % 4) != 0;
    else in_sop = ($urandom % 16) == 0;
    if ($urandom % 10 == 0) inv_sel = ~inv_sel;
    inv_req = inv_sel;
    #1;

    x_rdy = 0; x_en = 0; x_fl = 0; x_err = 0; x_ov = 0; x_sop = 0; x_eop = 0;
    x_inv = 0; x_busy = 0; x_bf = '0; x_tw = '0; x_idx = '0; j = 0;
    if (!r) begin
      x_inv  = minv;
      x_busy = (phase != 0);
      case (phase)
        0: begin x_rdy = 1; x_en = in_valid & in_sop; end
        1: if (pos != 0) begin
             x_rdy = 1; x_en = in_valid; x_err = in_valid & in_sop;
           end else begin
             x_rdy = in_valid & in_sop & (inv_req == minv); x_en = x_rdy;
           end
        default: begin x_en = 1; x_fl = 1; end
      endcase
      if (x_en) begin
        for (int s = 0; s < LOG2N; s++) begin
          off = N - (1 << (LOG2N - s)) + s * SLAT;
          sc  = (((phase == 0 ? 0 : pos) - off) % N + N) % N;
          x_bf[s] = ((sc >> (LOG2N - 1 - s)) & 1) != 0;
          x_tw[s*AW +: AW] = AW'((sc % (1 << (LOG2N - 1 - s))) * (1 << s));
        end
        k = (phase == 0) ? 1 : e + 1;
        j = k - L - 1;
        if (k > L && j < nin * N) begin
          x_ov  = 1;
          x_sop = (j % N) == 0;
          x_eop = (j % N) == N - 1;
          jm = LOG2N'(j % N);
          for (int b = 0; b < LOG2N; b++) x_idx[b] = jm[LOG2N-1-b];
        end
      end
    end

    check_eq("in_ready", in_ready, x_rdy);
    check_eq("en", en, x_en);
    check_eq("flush", flush, x_fl);
    check_eq("inv", inv, x_inv);
    check_eq("busy", busy, x_busy);
    check_eq("sop_err", sop_err, x_err);
    check_eq("out_valid", out_valid, x_ov);
    check_eq("out_sop", out_sop, x_sop);
    check_eq("out_eop", out_eop, x_eop);
    if (x_ov || r) check_eq("out_idx", out_idx, x_idx);
    if (x_en || r) begin
      check_eq("bf_sel", bf_sel, x_bf);
      check_eq("tw_addr", tw_addr, x_tw);
    end

    if (r) begin
      phase = 0; e = 0; nin = 0; minv = 0;
    end else begin
      case (phase)
        0: if (x_en) begin phase = 1; e = 1; nin = 1; minv = inv_req; end
        1: if (x_en) begin
             if (pos == 0) nin++;
             e++;
           end else if (pos == 0) phase = 2;
        default: begin
          e++;
          if (x_eop && (j / N) + 1 == nin) begin phase = 0; e = 0; end
        end
      endcase
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_sop = 1'b1; inv_req = 1'b0;
    do_cycle(1'b1);
    do_cycle(1'b1);
    for (int i = 0; i < 4000; i++) begin
      do_cycle((i == 700) || (i > 20 && ($urandom % 400) == 0));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
